pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the fetch PC register for the pipelined core and decides the next PC each cycle.
- Arbitrates between three sources, in priority order:
  - trap redirect
  - EX-stage branch/jump/jalr resolution, using the existing NPCOp encoding
  - ID-stage load-use stall
- Drives the instruction-memory address under a ready handshake.
- Generates IF/ID and ID/EX flush pulses. Holds a redirect pending while an instruction-memory fetch is outstanding.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the redirect event counter.

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  synchronous active-high reset
- stall_id  input  1  load-use hazard; hold PC and IF/ID
- ex_valid  input  1  EX stage holds a real (non-bubble) instruction
- ex_npcop  input  3  NPC_PLUS4=000, NPC_BRANCH=001, NPC_JUMP=010, NPC_JALR=100
- ex_zero  input  1  branch condition from EX ALU
- ex_pc  input  32  PC of EX-stage instruction
- ex_imm  input  32  immediate of EX-stage instruction
- ex_aluout  input  32  ALU result (jalr base)
- trap_req  input  1  trap/exception redirect request
- trap_vec  input  32  trap target
- imem_ready  input  1  instruction memory returns data for pc_out this cycle
- pc_out  output  32  fetch address (registered PC)
- if_valid  output  1  fetched word is valid and is to be written into IF/ID
- pc_write  output  1  PC register updates at this edge
- flush_ifid  output  1  kill IF/ID contents
- flush_idex  output  1  kill ID/EX contents
- state_pend  output  1  1 when in PEND state
- redirect_cnt  output  CNT_W  count of redirect cycles, wraps

Behaviour:
- Reset (rst=1 at edge):
  - pc=RESET_PC, state=RUN, pend_tgt=0, redirect_cnt=0.
  - While rst=1: if_valid, pc_write, flush_ifid and flush_idex are all 0.
- take = ex_valid & ((op==BRANCH & ex_zero) | op==JUMP | op==JALR). Any other op code (including PLUS4 and undefined codes) is not taken.
- Targets, all mod 2^32, no alignment masking:
  - BRANCH/JUMP: ex_pc+ex_imm
  - JALR: ex_aluout+ex_imm
- redir = trap_req | take. redir_tgt = trap_req ? trap_vec : ex target. Trap wins when both are present.
- State RUN:
  - redir=1:
    - flush_ifid=flush_idex=1, combinational in the same cycle; if_valid=0.
    - imem_ready=1: pc<=redir_tgt, pc_write=1, stay RUN.
    - imem_ready=0: pend_tgt<=redir_tgt, pc held (address must stay stable for the outstanding fetch), go to PEND.
  - else stall_id=1: pc held, if_valid=0, pc_write=0. This applies regardless of imem_ready; the word is refetched later.
  - else imem_ready=1: pc<=pc+4, if_valid=1, pc_write=1.
  - else: pc held, if_valid=0.
- State PEND:
  - if_valid=0 always. The returning word is wrong-path and is discarded.
  - redir=1: flush_ifid=flush_idex=1; pend_tgt<=redir_tgt, so the newer request overwrites.
  - imem_ready=1: pc<=(redir ? redir_tgt : pend_tgt), pc_write=1, go to RUN.
  - stall_id is ignored in PEND.
- redirect_cnt increments by 1 at each edge where redir=1 and rst=0. It wraps from all-ones to 0.
- Simultaneous stall_id and redir: redir wins, because the stalled ID instruction is wrong-path.
- Reset asserted in PEND: pending target is dropped; pc=RESET_PC.
- pc_out = pc register, with no combinational path from inputs.
- state_pend reflects the current state register.

Test Plan:
- Reset, then imem_ready=1 held for 3 cycles -> pc_out 0x0, 0x4, 0x8, 0xC; if_valid=1 each cycle after reset.
- pc=0x10, ex_valid=1, op=BRANCH, ex_zero=1, ex_pc=0x8, ex_imm=0x20, imem_ready=1 -> flush_ifid=flush_idex=1 that cycle; next pc_out=0x28; cnt=1. Repeat with ex_zero=0 -> no flush; pc becomes 0x14.
- op=JALR, ex_aluout=0x100, ex_imm=0xFFFFFFFC, while imem_ready=0 -> state_pend=1, pc held; 2 cycles later imem_ready=1 -> if_valid=0, next pc_out=0xFC, state RUN.
- In PEND with pend_tgt=0x40, assert trap_req with trap_vec=0x80 and imem_ready=1 in the same cycle -> flushes asserted; pc_out=0x80; cnt incremented.
- stall_id=1 for 2 cycles with imem_ready=1 at pc=0x20 -> pc_out stays 0x20, if_valid=0; on release pc advances to 0x24. stall_id=1 with simultaneous JUMP (ex_pc=0x20, ex_imm=0x10) -> redirect to 0x30.
- rst asserted while in PEND -> pc_out=RESET_PC, state_pend=0, redirect_cnt=0. Separately, preload 0xFFFF redirect events and issue one more -> redirect_cnt=0.

Source files
------------

// File: rtl/pc_sequencer.sv
// Fetch PC owner: arbitrates trap, EX redirect and load-use stall,
// and holds a redirect pending while an imem fetch is outstanding.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall_id,
  input  logic             ex_valid,
  input  logic [2:0]       ex_npcop,
  input  logic             ex_zero,
  input  logic [31:0]      ex_pc,
  input  logic [31:0]      ex_imm,
  input  logic [31:0]      ex_aluout,
  input  logic             trap_req,
  input  logic [31:0]      trap_vec,
  input  logic             imem_ready,
  output logic [31:0]      pc_out,
  output logic             if_valid,
  output logic             pc_write,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             state_pend,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  typedef enum logic {RUN, PEND} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic        is_br, is_jmp, is_jalr;
  logic        take, redir;
  logic [31:0] ex_tgt, redir_tgt;

  assign is_br   = ex_npcop == NPC_BRANCH;
  assign is_jmp  = ex_npcop == NPC_JUMP;
  assign is_jalr = ex_npcop == NPC_JALR;

  assign take = ex_valid & ((is_br & ex_zero) | is_jmp | is_jalr);
  assign ex_tgt = is_jalr ? ex_aluout + ex_imm
                          : ex_pc + ex_imm;

  // Trap outranks any EX-stage redirect
  assign redir     = trap_req | take;
  assign redir_tgt = trap_req ? trap_vec : ex_tgt;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pend_d     = pend_q;
    cnt_d      = cnt_q;
    if_valid   = 1'b0;
    pc_write   = 1'b0;
    flush_ifid = 1'b0;
    flush_idex = 1'b0;
    if (!rst) begin
      if (redir) begin
        cnt_d      = cnt_q + 1'b1;
        flush_ifid = 1'b1;
        flush_idex = 1'b1;
      end
      unique case (state_q)
        RUN: begin
          if (redir) begin
            if (imem_ready) begin
              pc_d     = redir_tgt;
              pc_write = 1'b1;
            end else begin
              pend_d  = redir_tgt;
              state_d = PEND;
            end
          end else if (!stall_id && imem_ready) begin
            pc_d     = pc_q + 32'd4;
            if_valid = 1'b1;
            pc_write = 1'b1;
          end
        end
        PEND: begin
          if (redir) pend_d = redir_tgt;
          // Returning word is wrong-path; only the address moves
          if (imem_ready) begin
            pc_d     = redir ? redir_tgt : pend_q;
            pc_write = 1'b1;
            state_d  = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      pend_q  <= 32'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
    end
  end

  assign pc_out       = pc_q;
  assign state_pend   = state_q == PEND;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; a CNT_W=4 copy
// shares the stimulus so counter wrap is reached quickly.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_id;
  logic        ex_valid;
  logic [2:0]  ex_npcop;
  logic        ex_zero;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [31:0] ex_aluout;
  logic        trap_req;
  logic [31:0] trap_vec;
  logic        imem_ready;

  logic [31:0] pc_out, s_pc_out;
  logic        if_valid, s_if_valid;
  logic        pc_write, s_pc_write;
  logic        flush_ifid, s_flush_ifid;
  logic        flush_idex, s_flush_idex;
  logic        state_pend, s_state_pend;
  logic [15:0] redirect_cnt;
  logic [3:0]  s_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(.RESET_PC(32'h0), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_npcop(ex_npcop),
    .ex_zero(ex_zero), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_aluout(ex_aluout), .trap_req(trap_req),
    .trap_vec(trap_vec), .imem_ready(imem_ready),
    .pc_out(pc_out), .if_valid(if_valid),
    .pc_write(pc_write), .flush_ifid(flush_ifid),
    .flush_idex(flush_idex), .state_pend(state_pend),
    .redirect_cnt(redirect_cnt)
  );

  pc_sequencer #(.RESET_PC(32'h0), .CNT_W(4)) u_small (
    .clk(clk), .rst(rst), .stall_id(stall_id),
    .ex_valid(ex_valid), .ex_npcop(ex_npcop),
    .ex_zero(ex_zero), .ex_pc(ex_pc), .ex_imm(ex_imm),
    .ex_aluout(ex_aluout), .trap_req(trap_req),
    .trap_vec(trap_vec), .imem_ready(imem_ready),
    .pc_out(s_pc_out), .if_valid(s_if_valid),
    .pc_write(s_pc_write), .flush_ifid(s_flush_ifid),
    .flush_idex(s_flush_idex), .state_pend(s_state_pend),
    .redirect_cnt(s_cnt)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ex_clear;
    ex_valid  = 1'b0;
    ex_npcop  = 3'b000;
    ex_zero   = 1'b0;
    ex_pc     = 32'h0;
    ex_imm    = 32'h0;
    ex_aluout = 32'h0;
  endtask

  task automatic chk_flush(input string tag, input logic v);
    chk({tag, "_fifid"}, {31'd0, flush_ifid}, {31'd0, v});
    chk({tag, "_fidex"}, {31'd0, flush_idex}, {31'd0, v});
  endtask

  initial begin
    rst = 1'b1; stall_id = 1'b0;
    ex_clear();
    trap_req = 1'b1; trap_vec = 32'h44;
    imem_ready = 1'b1;
    tick();
    #1;
    chk("rst_ifv", {31'd0, if_valid}, 32'd0);
    chk("rst_pcw", {31'd0, pc_write}, 32'd0);
    chk_flush("rst", 1'b0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_pend", {31'd0, state_pend}, 32'd0);
    chk("rst_cnt", {16'd0, redirect_cnt}, 32'd0);
    tick();
    chk("rst_cnt2", {16'd0, redirect_cnt}, 32'd0);

    // sequential fetch
    rst = 1'b0; trap_req = 1'b0;
    #1;
    chk("seq_ifv0", {31'd0, if_valid}, 32'd1);
    chk("seq_pc0", pc_out, 32'h0);
    tick(); chk("seq_pc4", pc_out, 32'h4);
    chk("seq_ifv4", {31'd0, if_valid}, 32'd1);
    tick(); chk("seq_pc8", pc_out, 32'h8);
    tick(); chk("seq_pcC", pc_out, 32'hC);
    tick(); chk("seq_pc10", pc_out, 32'h10);

    // branch not taken
    ex_valid = 1'b1; ex_npcop = 3'b001;
    ex_zero = 1'b0; ex_pc = 32'h8; ex_imm = 32'h20;
    #1;
    chk_flush("bnt", 1'b0);
    tick(); chk("bnt_pc", pc_out, 32'h14);

    // branch taken
    ex_zero = 1'b1;
    #1;
    chk_flush("bt", 1'b1);
    chk("bt_ifv", {31'd0, if_valid}, 32'd0);
    tick();
    chk("bt_pc", pc_out, 32'h28);
    chk("bt_cnt", {16'd0, redirect_cnt}, 32'd1);

    // jalr with fetch outstanding
    ex_npcop = 3'b100; ex_aluout = 32'h100;
    ex_imm = 32'hFFFF_FFFC; imem_ready = 1'b0;
    #1;
    chk_flush("jr", 1'b1);
    chk("jr_pcw", {31'd0, pc_write}, 32'd0);
    tick();
    chk("jr_pend", {31'd0, state_pend}, 32'd1);
    chk("jr_hold", pc_out, 32'h28);
    chk("jr_cnt", {16'd0, redirect_cnt}, 32'd2);
    ex_clear();
    stall_id = 1'b1;
    tick();
    chk("jr_pend2", {31'd0, state_pend}, 32'd1);
    chk("jr_hold2", pc_out, 32'h28);
    imem_ready = 1'b1;
    #1;
    chk("jr_ifv", {31'd0, if_valid}, 32'd0);
    chk("jr_pcw2", {31'd0, pc_write}, 32'd1);
    chk_flush("jr2", 1'b0);
    tick();
    stall_id = 1'b0;
    chk("jr_pc", pc_out, 32'hFC);
    chk("jr_run", {31'd0, state_pend}, 32'd0);
    chk("jr_cnt2", {16'd0, redirect_cnt}, 32'd2);

    // jump into PEND, pend_tgt=0x40, then trap overrides
    ex_valid = 1'b1; ex_npcop = 3'b010;
    ex_pc = 32'h30; ex_imm = 32'h10; imem_ready = 1'b0;
    tick();
    chk("tp_pend", {31'd0, state_pend}, 32'd1);
    ex_clear();
    trap_req = 1'b1; trap_vec = 32'h80; imem_ready = 1'b1;
    #1;
    chk_flush("tp", 1'b1);
    chk("tp_ifv", {31'd0, if_valid}, 32'd0);
    tick();
    chk("tp_pc", pc_out, 32'h80);
    chk("tp_run", {31'd0, state_pend}, 32'd0);
    chk("tp_cnt", {16'd0, redirect_cnt}, 32'd4);

    // trap to 0x20 wins over simultaneous jump
    ex_valid = 1'b1; ex_npcop = 3'b010;
    ex_pc = 32'h500; ex_imm = 32'h4;
    trap_vec = 32'h20;
    tick();
    trap_req = 1'b0;
    ex_clear();
    chk("tw_pc", pc_out, 32'h20);
    chk("tw_cnt", {16'd0, redirect_cnt}, 32'd5);

    // load-use stall
    stall_id = 1'b1;
    #1;
    chk("st_ifv", {31'd0, if_valid}, 32'd0);
    chk("st_pcw", {31'd0, pc_write}, 32'd0);
    tick(); chk("st_pc1", pc_out, 32'h20);
    tick(); chk("st_pc2", pc_out, 32'h20);
    stall_id = 1'b0;
    #1;
    chk("st_ifv2", {31'd0, if_valid}, 32'd1);
    tick(); chk("st_pc3", pc_out, 32'h24);

    // stall with jump: redirect wins
    stall_id = 1'b1;
    ex_valid = 1'b1; ex_npcop = 3'b010;
    ex_pc = 32'h20; ex_imm = 32'h10;
    #1;
    chk_flush("sj", 1'b1);
    tick();
    chk("sj_pc", pc_out, 32'h30);
    chk("sj_cnt", {16'd0, redirect_cnt}, 32'd6);
    stall_id = 1'b0;

    // undefined op and bubble jump are not taken
    ex_npcop = 3'b011;
    #1;
    chk_flush("ud", 1'b0);
    tick(); chk("ud_pc", pc_out, 32'h34);
    ex_npcop = 3'b010; ex_valid = 1'b0;
    #1;
    chk_flush("bub", 1'b0);
    tick(); chk("bub_pc", pc_out, 32'h38);

    // reset while PEND
    ex_valid = 1'b1; imem_ready = 1'b0;
    tick();
    chk("rp_pend", {31'd0, state_pend}, 32'd1);
    ex_clear();
    rst = 1'b1;
    tick();
    chk("rp_pc", pc_out, 32'h0);
    chk("rp_pend0", {31'd0, state_pend}, 32'd0);
    chk("rp_cnt", {16'd0, redirect_cnt}, 32'd0);
    rst = 1'b0; imem_ready = 1'b1;
    tick();
    chk("rp_drop", pc_out, 32'h4);

    // counter wrap on the narrow copy
    trap_req = 1'b1; trap_vec = 32'h200;
    for (int i = 0; i < 15; i++) tick();
    chk("wr_f", {28'd0, s_cnt}, 32'hF);
    tick();
    trap_req = 1'b0;
    chk("wr_0", {28'd0, s_cnt}, 32'h0);
    chk("wr_big", {16'd0, redirect_cnt}, 32'd16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
